// File: rtl/dmem_mmio_if.sv
// Data-memory request/response bundle between the datapath and the memory stage.
// The datapath drives the request; the memory stage returns read data in the same cycle.
interface dmem_mmio_if #(
    parameter int N = 64
);
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;

    modport master (
        output DM_addr,
        output DM_writeData,
        output DM_writeEnable,
        output DM_readEnable,
        input  DM_readData
    );

    modport slave (
        input  DM_addr,
        input  DM_writeData,
        input  DM_writeEnable,
        input  DM_readEnable,
        output DM_readData
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory stage: doubleword RAM plus an MMIO window holding a cycle counter,
// a compare timer with sticky match, a GPIO output register and a sticky bus-error flag.
module dmem_mmio #(
    parameter int N     = 64,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    dmem_mmio_if.slave   dm,
    output logic [N-1:0] gpio_out,
    output logic         irq,
    output logic         bus_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [N-1:0] ADDR_CYCLE  = N'(64'h0000_0000_0000_1000);
    localparam logic [N-1:0] ADDR_CMP    = N'(64'h0000_0000_0000_1008);
    localparam logic [N-1:0] ADDR_STATUS = N'(64'h0000_0000_0000_1010);
    localparam logic [N-1:0] ADDR_GPIO   = N'(64'h0000_0000_0000_1018);

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_RAM    = 3'd1,
        SEL_CYCLE  = 3'd2,
        SEL_CMP    = 3'd3,
        SEL_STATUS = 3'd4,
        SEL_GPIO   = 3'd5
    } sel_e;

    logic [N-1:0]  ram_r [DEPTH];
    logic [N-1:0]  cycle_r;
    logic [N-1:0]  cmp_r;
    logic [N-1:0]  gpio_r;
    logic          match_r;
    logic          bus_err_r;

    sel_e          sel_s;
    logic [AW-1:0] word_idx_s;
    logic          ram_hit_s;
    logic          misaligned_s;
    logic          rd_err_s;
    logic          wr_err_s;
    logic          wr_ok_s;
    logic          err_evt_s;
    logic [N-1:0]  rd_val_s;

    assign word_idx_s   = dm.DM_addr[3+AW-1:3];
    assign ram_hit_s    = (dm.DM_addr[N-1:3+AW] == {(N-3-AW){1'b0}});
    assign misaligned_s = (dm.DM_addr[2:0] != 3'b000);

    // Address decode; misaligned addresses are caught separately so RAM decode ignores [2:0].
    always_comb begin
        sel_s = SEL_NONE;
        if (ram_hit_s) begin
            sel_s = SEL_RAM;
        end else begin
            case (dm.DM_addr)
                ADDR_CYCLE:  sel_s = SEL_CYCLE;
                ADDR_CMP:    sel_s = SEL_CMP;
                ADDR_STATUS: sel_s = SEL_STATUS;
                ADDR_GPIO:   sel_s = SEL_GPIO;
                default:     sel_s = SEL_NONE;
            endcase
        end
    end

    assign rd_err_s  = misaligned_s | (sel_s == SEL_NONE);
    assign wr_err_s  = rd_err_s | (sel_s == SEL_CYCLE);
    assign wr_ok_s   = dm.DM_writeEnable & ~wr_err_s & ~reset;
    assign err_evt_s = (dm.DM_readEnable & rd_err_s) | (dm.DM_writeEnable & wr_err_s);

    // Read mux over pre-edge state, so a same-cycle write is never visible to the read.
    always_comb begin
        rd_val_s = {N{1'b0}};
        case (sel_s)
            SEL_RAM:    rd_val_s = ram_r[word_idx_s];
            SEL_CYCLE:  rd_val_s = cycle_r;
            SEL_CMP:    rd_val_s = cmp_r;
            SEL_STATUS: rd_val_s = {{(N-1){1'b0}}, match_r};
            SEL_GPIO:   rd_val_s = gpio_r;
            default:    rd_val_s = {N{1'b0}};
        endcase
    end

    // Gate the response: errored or disabled reads return zero.
    always_comb begin
        dm.DM_readData = {N{1'b0}};
        if (dm.DM_readEnable && !rd_err_s) begin
            dm.DM_readData = rd_val_s;
        end else begin
            dm.DM_readData = {N{1'b0}};
        end
    end

    // RAM storage, cleared as a whole on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_r[i] <= {N{1'b0}};
            end
        end else if (wr_ok_s && (sel_s == SEL_RAM)) begin
            ram_r[word_idx_s] <= dm.DM_writeData;
        end
    end

    // Peripheral registers; match set takes priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r   <= {N{1'b0}};
            cmp_r     <= {N{1'b1}};
            gpio_r    <= {N{1'b0}};
            match_r   <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            cycle_r <= cycle_r + N'(1'b1);
            if (wr_ok_s && (sel_s == SEL_CMP)) begin
                cmp_r <= dm.DM_writeData;
            end
            if (wr_ok_s && (sel_s == SEL_GPIO)) begin
                gpio_r <= dm.DM_writeData;
            end
            if (cycle_r == cmp_r) begin
                match_r <= 1'b1;
            end else if (wr_ok_s && (sel_s == SEL_STATUS) && dm.DM_writeData[0]) begin
                match_r <= 1'b0;
            end
            if (err_evt_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign gpio_out = gpio_r;
    assign irq      = match_r;
    assign bus_err  = bus_err_r;
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected responses, a negedge monitor
// pops and compares read data and the registered side outputs.
module tb_dmem_mmio;
    logic        clk;
    logic        reset;
    logic [63:0] gpio_out;
    logic        irq;
    logic        bus_err;

    dmem_mmio_if #(.N(64)) dm ();

    dmem_mmio #(.N(64), .DEPTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .dm       (dm),
        .gpio_out (gpio_out),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    typedef struct {
        string       name;
        logic [63:0] exp;
    } rd_exp_t;

    typedef struct {
        string       name;
        logic        irq;
        logic [63:0] gpio;
        logic        berr;
    } side_exp_t;

    rd_exp_t     rd_q[$];
    side_exp_t   side_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        chk_side;
    logic [63:0] cyc_m;

    always #5 clk = ~clk;

    // Reference cycle count used only for scheduling stimulus.
    always @(posedge clk) cyc_m <= reset ? 64'd0 : cyc_m + 64'd1;

    // Monitor: compare whenever a read is presented or a side check is flagged.
    always @(negedge clk) begin
        rd_exp_t   r;
        side_exp_t s;
        if (dm.DM_readEnable) begin
            tests++;
            if (rd_q.size() == 0) begin
                fails++;
                $display("FAIL rd_q_empty: got read %h with no expected value", dm.DM_readData);
            end else begin
                r = rd_q.pop_front();
                if (dm.DM_readData !== r.exp) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", r.name, dm.DM_readData, r.exp);
                end
            end
        end
        if (chk_side) begin
            tests++;
            if (side_q.size() == 0) begin
                fails++;
                $display("FAIL side_q_empty: irq=%b gpio=%h bus_err=%b", irq, gpio_out, bus_err);
            end else begin
                s = side_q.pop_front();
                if (irq !== s.irq || gpio_out !== s.gpio || bus_err !== s.berr) begin
                    fails++;
                    $display("FAIL %s: got irq=%b gpio=%h bus_err=%b expected irq=%b gpio=%h bus_err=%b",
                             s.name, irq, gpio_out, bus_err, s.irq, s.gpio, s.berr);
                end
            end
        end
    end

    task automatic op(input logic [63:0] a, input logic [63:0] d, input logic we,
                      input logic re, input string nm, input logic [63:0] exp);
        rd_exp_t e;
        dm.DM_addr        = a;
        dm.DM_writeData   = d;
        dm.DM_writeEnable = we;
        dm.DM_readEnable  = re;
        if (re) begin
            e.name = nm;
            e.exp  = exp;
            rd_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk_side = 1'b0;
    endtask

    task automatic idle();
        op(64'd0, 64'd0, 1'b0, 1'b0, "", 64'd0);
    endtask

    task automatic expect_side(input string nm, input logic i, input logic [63:0] g, input logic b);
        side_exp_t s;
        s.name = nm;
        s.irq  = i;
        s.gpio = g;
        s.berr = b;
        side_q.push_back(s);
        chk_side = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input logic [63:0] t);
        for (int i = 0; i < 300; i++) begin
            if (cyc_m == t) break;
            idle();
        end
        if (cyc_m != t) begin
            tests++;
            fails++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc_m, t);
        end
    endtask

    initial begin
        clk               = 1'b0;
        reset             = 1'b1;
        chk_side          = 1'b0;
        dm.DM_addr        = 64'd0;
        dm.DM_writeData   = 64'd0;
        dm.DM_writeEnable = 1'b0;
        dm.DM_readEnable  = 1'b0;

        // Reset behaviour: writes dropped, reads return reset-state values.
        idle();
        op(64'h8, 64'h77, 1'b1, 1'b1, "rst_rd_ram", 64'd0);
        expect_side("rst_outs", 1'b0, 64'd0, 1'b0);
        op(64'h1008, 64'd0, 1'b0, 1'b1, "rst_cmp", 64'hFFFF_FFFF_FFFF_FFFF);
        reset = 1'b0;
        op(64'h1000, 64'd0, 1'b0, 1'b1, "cycle_first", 64'd0);
        op(64'h8, 64'd0, 1'b0, 1'b1, "rst_write_dropped", 64'd0);

        // Basic RAM write/read and read-during-write.
        op(64'h8, 64'hDEAD_BEEF, 1'b1, 1'b0, "", 64'd0);
        op(64'h8, 64'd0, 1'b0, 1'b1, "ram_rd", 64'hDEAD_BEEF);
        expect_side("no_err", 1'b0, 64'd0, 1'b0);
        op(64'h10, 64'd0, 1'b0, 1'b1, "ram_rd_zero", 64'd0);
        op(64'h8, 64'h5, 1'b1, 1'b1, "raw_old", 64'hDEAD_BEEF);
        op(64'h8, 64'd0, 1'b0, 1'b1, "raw_new", 64'h5);

        // Timer match and clear.
        do_reset();
        wait_cyc(64'd2);
        op(64'h1000, 64'd0, 1'b0, 1'b1, "cycle2", 64'd2);
        op(64'h1008, 64'd10, 1'b1, 1'b0, "", 64'd0);
        wait_cyc(64'd10);
        expect_side("irq_pre", 1'b0, 64'd0, 1'b0);
        idle();
        expect_side("irq_set", 1'b1, 64'd0, 1'b0);
        op(64'h1008, 64'd0, 1'b0, 1'b1, "cmp_rd", 64'd10);
        op(64'h1010, 64'd0, 1'b0, 1'b1, "status_rd", 64'd1);
        wait_cyc(64'd15);
        expect_side("irq_clr_same", 1'b1, 64'd0, 1'b0);
        op(64'h1010, 64'd1, 1'b1, 1'b0, "", 64'd0);
        expect_side("irq_clr", 1'b0, 64'd0, 1'b0);
        op(64'h1010, 64'd0, 1'b0, 1'b1, "status_clr", 64'd0);

        // Clear while matching: set wins; a write with bit0=0 does not clear.
        op(64'h1008, 64'd20, 1'b1, 1'b0, "", 64'd0);
        wait_cyc(64'd20);
        op(64'h1010, 64'd1, 1'b1, 1'b0, "", 64'd0);
        expect_side("set_wins", 1'b1, 64'd0, 1'b0);
        op(64'h1010, 64'd0, 1'b0, 1'b1, "status_set_wins", 64'd1);
        op(64'h1010, 64'h2, 1'b1, 1'b0, "", 64'd0);
        expect_side("bit1_no_clear", 1'b1, 64'd0, 1'b0);
        op(64'h1010, 64'd0, 1'b0, 1'b1, "status_upper_zero", 64'd1);

        // Error cases.
        do_reset();
        op(64'h4, 64'h1234, 1'b1, 1'b0, "", 64'd0);
        expect_side("err_misalign_wr", 1'b0, 64'd0, 1'b1);
        op(64'h0, 64'd0, 1'b0, 1'b1, "misalign_ram", 64'd0);

        do_reset();
        op(64'h2000, 64'd0, 1'b0, 1'b1, "unmapped_rd", 64'd0);
        expect_side("err_unmapped", 1'b0, 64'd0, 1'b1);
        idle();

        do_reset();
        op(64'h1000, 64'h100, 1'b1, 1'b0, "", 64'd0);
        expect_side("err_cycle_wr", 1'b0, 64'd0, 1'b1);
        op(64'h1000, 64'd0, 1'b0, 1'b1, "cycle_keeps", 64'd1);
        idle();
        expect_side("err_sticky", 1'b0, 64'd0, 1'b1);
        idle();

        do_reset();
        op(64'h2000, 64'hFF, 1'b0, 1'b0, "", 64'd0);
        expect_side("no_en_no_err", 1'b0, 64'd0, 1'b0);
        op(64'h100C, 64'd0, 1'b0, 1'b1, "misalign_rd", 64'd0);
        expect_side("err_misalign_rd", 1'b0, 64'd0, 1'b1);
        idle();

        // GPIO and mid-stream reset.
        do_reset();
        op(64'h1018, 64'hA5, 1'b1, 1'b0, "", 64'd0);
        expect_side("gpio_set", 1'b0, 64'hA5, 1'b0);
        op(64'h1018, 64'd0, 1'b0, 1'b1, "gpio_rd", 64'hA5);
        op(64'h10, 64'h99, 1'b1, 1'b0, "", 64'd0);
        op(64'h10, 64'd0, 1'b0, 1'b1, "ram_pre_rst", 64'h99);
        reset = 1'b1;
        op(64'h1018, 64'hFF, 1'b1, 1'b0, "", 64'd0);
        reset = 1'b0;
        expect_side("gpio_rst", 1'b0, 64'd0, 1'b0);
        op(64'h1000, 64'd0, 1'b0, 1'b1, "cycle_after_rst", 64'd0);
        op(64'h10, 64'd0, 1'b0, 1'b1, "ram_cleared", 64'd0);
        op(64'h1018, 64'd0, 1'b0, 1'b1, "gpio_rd_rst", 64'd0);
        idle();
        idle();

        if (rd_q.size() != 0 || side_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover: rd_q=%0d side_q=%0d expected 0 0", rd_q.size(), side_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
